inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Program-load controller for the filter's instruction memory (`inst_mem`). It accepts a program from the host as a stream of 32-bit half-words, assembles 64-bit BPF instructions and writes them sequentially from address 0. While a load is in progress it also fences the CPU's fetch port, so the processor never reads a half-written program. It sits between the host configuration path and `inst_mem`, in front of the CPU's instruction-fetch port.

## Interface

Parameters:
- `ADDR_WIDTH`, default 10: instruction memory address width; depth is DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 64: instruction width. Fixed at 64, i.e. two 32-bit beats per instruction.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a new program load at address 0.
- `in_data`  in  32  host beat; low half first, then high half.
- `in_valid`  in  1  beat valid.
- `in_last`  in  1  last instruction marker; sampled only on high-half beats.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `mem_wr_addr`  out  ADDR_WIDTH  to `inst_mem` `wr_addr`.
- `mem_wr_data`  out  64  to `inst_mem` `wr_data`.
- `mem_wr_en`  out  1  to `inst_mem` `wr_en`.
- `cpu_rd_en`  in  1  CPU fetch request.
- `mem_rd_en`  out  1  to `inst_mem` `rd_en`.
- `cpu_stall`  out  1  fetch refused this cycle.
- `loading`  out  1  a load is in progress.
- `load_done`  out  1  one-cycle completion pulse.
- `prog_len`  out  ADDR_WIDTH+1  number of instructions written by the last or current load.
- `ovf`  out  1  the program exceeded DEPTH.

## Operation

- FSM states: IDLE, LOAD_LO, LOAD_HI.
- IDLE --`start`--> LOAD_LO. On this transition: write pointer := 0, `prog_len` := 0, `ovf` := 0.
- LOAD_LO: an accepted beat latches `in_data` into the low-half register, then goes to LOAD_HI.
- LOAD_HI: an accepted beat forms the word {`in_data`, low half}.
  - If `ovf` = 0, the word is written at the pointer; then pointer += 1 and `prog_len` += 1.
  - If `in_last` = 1, go to IDLE and raise `load_done`; otherwise go to LOAD_LO.
- `in_ready` = (state ≠ IDLE) & ~`start`.
- `loading` = (state ≠ IDLE) | `mem_wr_en`.
- Overflow:
  - The write that uses address DEPTH-1 sets `ovf` to 1. The pointer does not wrap to 0 and `prog_len` saturates at DEPTH.
  - While `ovf` = 1, beats are still accepted and discarded until `in_last`.
  - `load_done` still pulses at the end; `ovf` holds until the next `start`.
- `start` during LOAD_LO or LOAD_HI aborts the load: any partial half is discarded, pointer, `prog_len` and `ovf` are cleared, and the state goes to LOAD_LO. Words already written remain in memory.
- `start` wins over a simultaneous `in_valid`; that beat is not accepted.
- Fetch gating:
  - `mem_rd_en` = `cpu_rd_en` & ~`loading`.
  - `cpu_stall` = `cpu_rd_en` & `loading`.
  - Both are purely combinational.
- Reset: state IDLE. All outputs are 0, including `mem_wr_addr` and `mem_wr_data`. Memory contents are untouched. A reset in the middle of a load abandons it and does not pulse `load_done`.

## Timing

- A high-half beat accepted in cycle N gives `mem_wr_en` = 1 in cycle N+1, with the registered address and data. `mem_wr_en` is a one-cycle pulse.
- `load_done` is asserted in cycle N+1, in the same cycle as the final `mem_wr_en`.
- Throughput: one instruction per 2 accepted beats. There are no bubbles; `in_ready` stays high through LOAD_LO and LOAD_HI.
- `loading` covers the final write cycle. The first unstalled fetch is therefore in cycle N+2, so it reads the completed program. This relies on `inst_mem`'s 1-cycle read latency.
- `prog_len` and `ovf` update in cycle N+1.

## Configuration

- Macro: `INST_LOADER_CKSUM_EN`.
- When defined:
  - Adds output `cksum` (out, 64): the running XOR of every word actually written.
  - `cksum` is cleared by reset and by `start`, and updates in the same cycle as `mem_wr_en`.
  - The host compares it against its own program XOR.
- When undefined: the `cksum` port and its logic are absent; all other behaviour is identical.

## Test plan

- Basic load:
  - Stimulus: after reset, `start`, then the 4 beats 0xFFFF, 0x00060000, 0x0, 0x00060000 (the second high half with `in_last`).
  - Required: 2 writes, 0x000600000000FFFF at address 0 and 0x0006000000000000 at address 1; `load_done` in the cycle of the second write; `prog_len` = 2.
- Back-pressure:
  - Stimulus: `in_valid` toggled every other cycle across a 16-instruction load.
  - Required: no beats lost; 16 writes at addresses 0..15; `prog_len` = 16.
- Fetch fence:
  - Stimulus: `cpu_rd_en` held at 1 throughout a load.
  - Required: `mem_rd_en` = 0 and `cpu_stall` = 1 from the `start` cycle+1 through the final write cycle; `mem_rd_en` = 1 in the following cycle.
- Overflow:
  - Stimulus: ADDR_WIDTH = 2, load 6 instructions.
  - Required: writes to addresses 0..3 only; `ovf` = 1; `prog_len` = 4; `load_done` pulses after the 6th instruction.
- Abort:
  - Stimulus: `start` after a low-half beat, then a 1-instruction load 0xA/0xB.
  - Required: a single write of 0x0000000B0000000A at address 0; `prog_len` = 1.
- Reset mid-load:
  - Stimulus: assert `rst` between halves.
  - Required: immediately `in_ready` = 0, `loading` = 0, no `load_done`, and no write on the following cycles.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Program-load controller: assembles 64-bit BPF instructions from 32-bit host beats into inst_mem
// and fences CPU fetch while loading. Optional running XOR checksum via INST_LOADER_CKSUM_EN.
module inst_mem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    input  logic                  cpu_rd_en,
    output logic                  mem_rd_en,
    output logic                  cpu_stall,
    output logic                  loading,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  ovf
`ifdef INST_LOADER_CKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] cksum
`endif
);

    localparam int unsigned HALF_WIDTH = 32;
    localparam int unsigned PLEN_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD_LO = 2'd1;
    localparam logic [1:0] S_LOAD_HI = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  accept;
    logic                  lo_fire;
    logic                  hi_fire;
    logic                  wr_fire;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [HALF_WIDTH-1:0] lo_half;
    logic [DATA_WIDTH-1:0] word;

    // Next-state and beat handshake; start always wins over a beat.
    always_comb begin
        state_nxt = state;
        in_ready  = (state != S_IDLE) && !start;
        accept    = in_ready && in_valid;
        lo_fire   = accept && (state == S_LOAD_LO);
        hi_fire   = accept && (state == S_LOAD_HI);
        wr_fire   = hi_fire && !ovf;
        if (start) begin
            state_nxt = S_LOAD_LO;
        end else begin
            case (state)
                S_LOAD_LO: if (accept) state_nxt = S_LOAD_HI;
                S_LOAD_HI: if (accept) state_nxt = in_last ? S_IDLE : S_LOAD_LO;
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    assign word = DATA_WIDTH'({in_data, lo_half});

    // Write path; pointer parks on the last address once the memory is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            lo_half     <= '0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_en   <= 1'b0;
            load_done   <= 1'b0;
            prog_len    <= '0;
            ovf         <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            load_done <= 1'b0;
            if (start) begin
                wr_ptr   <= '0;
                prog_len <= '0;
                ovf      <= 1'b0;
            end else begin
                if (lo_fire) lo_half <= in_data;
                if (wr_fire) begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= wr_ptr;
                    mem_wr_data <= word;
                    prog_len    <= prog_len + PLEN_WIDTH'(1);
                    if (wr_ptr == LAST_ADDR) ovf <= 1'b1;
                    else                     wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                end
                if (hi_fire && in_last) load_done <= 1'b1;
            end
        end
    end

`ifdef INST_LOADER_CKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cksum <= '0;
        else if (start)   cksum <= '0;
        else if (wr_fire) cksum <= cksum ^ word;
    end
`endif

    // The final write cycle stays fenced so the first fetch sees the complete program.
    assign loading   = (state != S_IDLE) || mem_wr_en;
    assign mem_rd_en = cpu_rd_en && !loading;
    assign cpu_stall = cpu_rd_en && loading;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: a default-size instance plus a 4-deep instance for overflow.
module tb_inst_mem_loader;

    localparam int unsigned AW  = 10;
    localparam int unsigned AWS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_last;
    logic          cpu_rd_en;

    logic          in_ready, mem_wr_en, mem_rd_en, cpu_stall, loading, load_done, ovf;
    logic [AW-1:0] mem_wr_addr;
    logic [63:0]   mem_wr_data;
    logic [AW:0]   prog_len;

    logic           s_in_ready, s_mem_wr_en, s_mem_rd_en, s_cpu_stall, s_loading, s_load_done, s_ovf;
    logic [AWS-1:0] s_mem_wr_addr;
    logic [63:0]    s_mem_wr_data;
    logic [AWS:0]   s_prog_len;
`ifdef INST_LOADER_CKSUM_EN
    logic [63:0]    cksum, s_cksum;
`endif

    always #5 clk = ~clk;

    inst_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .cpu_rd_en(cpu_rd_en),
        .mem_rd_en(mem_rd_en), .cpu_stall(cpu_stall), .loading(loading),
        .load_done(load_done), .prog_len(prog_len), .ovf(ovf)
`ifdef INST_LOADER_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    inst_mem_loader #(.ADDR_WIDTH(AWS), .DATA_WIDTH(64)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(s_in_ready), .mem_wr_addr(s_mem_wr_addr),
        .mem_wr_data(s_mem_wr_data), .mem_wr_en(s_mem_wr_en), .cpu_rd_en(cpu_rd_en),
        .mem_rd_en(s_mem_rd_en), .cpu_stall(s_cpu_stall), .loading(s_loading),
        .load_done(s_load_done), .prog_len(s_prog_len), .ovf(s_ovf)
`ifdef INST_LOADER_CKSUM_EN
        , .cksum(s_cksum)
`endif
    );

    logic [AW-1:0]  wr_addr_q[$];
    logic [63:0]    wr_data_q[$];
    logic [AWS-1:0] s_addr_q[$];
    int done_cnt    = 0;
    int done_wr_cnt = 0;
    int s_done_cnt  = 0;
    int fence_leak  = 0;
    logic fence_on  = 1'b0;
    int tests = 0;
    int fails = 0;

    // Write/pulse logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_addr_q.push_back(mem_wr_addr);
            wr_data_q.push_back(mem_wr_data);
        end
        if (load_done) done_cnt++;
        if (load_done && mem_wr_en) done_wr_cnt++;
        if (s_mem_wr_en) s_addr_q.push_back(s_mem_wr_addr);
        if (s_load_done) s_done_cnt++;
        if (fence_on && (mem_rd_en || !cpu_stall)) fence_leak++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int   n;
        logic ok;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            ok = in_ready;
            tick();
            if (ok) break;
            n++;
            if (n > 50) begin
                check("beat_timeout", 64'(in_ready), 64'(1));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_instr(input logic [31:0] lo, input logic [31:0] hi, input logic last);
        send_beat(lo, 1'b0);
        send_beat(hi, last);
    endtask

    initial begin
        int base, d0, dw, leak0, sbase, sd0;
        rst = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; cpu_rd_en = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_in_ready",  64'(in_ready), 64'(0));
        check("rst_loading",   64'(loading), 64'(0));
        check("rst_wr_en",     64'(mem_wr_en), 64'(0));
        check("rst_wr_addr",   64'(mem_wr_addr), 64'(0));
        check("rst_wr_data",   mem_wr_data, 64'(0));
        check("rst_prog_len",  64'(prog_len), 64'(0));
        check("rst_ovf",       64'(ovf), 64'(0));
        check("rst_load_done", 64'(load_done), 64'(0));
        rst = 1'b0;
        tick();

        // Basic load
        base = wr_addr_q.size(); d0 = done_cnt; dw = done_wr_cnt;
        pulse_start();
        send_instr(32'h0000FFFF, 32'h00060000, 1'b0);
        send_instr(32'h00000000, 32'h00060000, 1'b1);
        @(negedge clk);
        check("basic_done_pulse", 64'(load_done), 64'(1));
        check("basic_last_wr_en", 64'(mem_wr_en), 64'(1));
        check("basic_prog_len",   64'(prog_len), 64'(2));
`ifdef INST_LOADER_CKSUM_EN
        check("basic_cksum", cksum, 64'h000000000000FFFF);
`endif
        tick();
        check("basic_nwr",      64'(wr_addr_q.size() - base), 64'(2));
        check("basic_addr0",    64'(wr_addr_q[base]), 64'(0));
        check("basic_data0",    wr_data_q[base], 64'h000600000000FFFF);
        check("basic_addr1",    64'(wr_addr_q[base+1]), 64'(1));
        check("basic_data1",    wr_data_q[base+1], 64'h0006000000000000);
        check("basic_done_cnt", 64'(done_cnt - d0), 64'(1));
        check("basic_done_wr",  64'(done_wr_cnt - dw), 64'(1));
        check("basic_idle",     64'(loading), 64'(0));

        // Back-pressure: one idle cycle between every beat
        base = wr_addr_q.size();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send_beat(32'(100 + 2 * i), 1'b0);
            tick();
            send_beat(32'hA0000000 | 32'(i), i == 15);
            tick();
        end
        tick();
        check("bp_nwr",      64'(wr_addr_q.size() - base), 64'(16));
        check("bp_prog_len", 64'(prog_len), 64'(16));
        for (int i = 0; i < 16; i++) begin
            check("bp_addr", 64'(wr_addr_q[base+i]), 64'(i));
            check("bp_data", wr_data_q[base+i], {32'hA0000000 | 32'(i), 32'(100 + 2 * i)});
        end

        // Fetch fence
        cpu_rd_en = 1'b1;
        @(negedge clk);
        check("fence_idle_rd", 64'(mem_rd_en), 64'(1));
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        leak0 = fence_leak;
        fence_on = 1'b1;
        send_instr(32'h1, 32'h2, 1'b0);
        send_instr(32'h3, 32'h4, 1'b1);
        @(negedge clk);
        check("fence_final_wr",    64'(mem_wr_en), 64'(1));
        check("fence_final_rd",    64'(mem_rd_en), 64'(0));
        check("fence_final_stall", 64'(cpu_stall), 64'(1));
        tick();
        fence_on = 1'b0;
        @(negedge clk);
        check("fence_after_rd",    64'(mem_rd_en), 64'(1));
        check("fence_after_stall", 64'(cpu_stall), 64'(0));
        check("fence_leak",        64'(fence_leak - leak0), 64'(0));
        tick();
        cpu_rd_en = 1'b0;

        // Overflow on the 4-deep instance
        sbase = s_addr_q.size(); sd0 = s_done_cnt;
        pulse_start();
        for (int i = 0; i < 6; i++) send_instr(32'(i), 32'hC0000000 | 32'(i), i == 5);
        @(negedge clk);
        check("ovf_done",     64'(s_load_done), 64'(1));
        check("ovf_no_wr",    64'(s_mem_wr_en), 64'(0));
        check("ovf_flag",     64'(s_ovf), 64'(1));
        check("ovf_prog_len", 64'(s_prog_len), 64'(4));
        tick();
        check("ovf_nwr",      64'(s_addr_q.size() - sbase), 64'(4));
        for (int i = 0; i < 4; i++) check("ovf_addr", 64'(s_addr_q[sbase+i]), 64'(i));
        check("ovf_done_cnt", 64'(s_done_cnt - sd0), 64'(1));
        check("ovf_big_flag", 64'(ovf), 64'(0));

        // Abort after a low half
        base = wr_addr_q.size();
        pulse_start();
        send_beat(32'h00000055, 1'b0);
        pulse_start();
        send_instr(32'h0000000A, 32'h0000000B, 1'b1);
        @(negedge clk);
        check("abort_prog_len", 64'(prog_len), 64'(1));
        tick();
        check("abort_nwr",  64'(wr_addr_q.size() - base), 64'(1));
        check("abort_addr", 64'(wr_addr_q[base]), 64'(0));
        check("abort_data", wr_data_q[base], 64'h0000000B0000000A);

        // Reset between halves
        base = wr_addr_q.size(); d0 = done_cnt;
        pulse_start();
        send_beat(32'h00000077, 1'b0);
        in_valid = 1'b1; in_data = 32'h00000088; in_last = 1'b1;
        rst = 1'b1;
        #1;
        check("rstmid_in_ready", 64'(in_ready), 64'(0));
        check("rstmid_loading",  64'(loading), 64'(0));
        tick();
        rst = 1'b0;
        repeat (3) tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        check("rstmid_nwr",      64'(wr_addr_q.size() - base), 64'(0));
        check("rstmid_no_done",  64'(done_cnt - d0), 64'(0));
        check("rstmid_prog_len", 64'(prog_len), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
